// File: rtl/matmul_nxn_seq_pkg.sv
// Shared types and helpers for the sequential NxN fixed-point matrix multiplier.
package matmul_nxn_seq_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCompute = 2'd1,
        StStore   = 2'd2,
        StReady   = 2'd3
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) res = i + 1;
        end
        return res;
    endfunction

    // Element (0,0) lives at the MSBs of a packed matrix.
    function automatic int elem_lsb(input int r, input int c, input int n, input int w);
        return w * (n * n - 1 - (r * n + c));
    endfunction

    function automatic logic signed [127:0] sat_max(input int unsigned w);
        logic signed [127:0] one;
        one = 128'sd1;
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic signed [127:0] sat_min(input int unsigned w);
        logic signed [127:0] one;
        one = 128'sd1;
        return -(one <<< (w - 1));
    endfunction

endpackage

// File: rtl/matmul_mac_lane.sv
// One multiply-accumulate lane: signed W x W product into a non-wrapping
// accumulator, plus floor-shift and saturation down to W bits.
module matmul_mac_lane
    import matmul_nxn_seq_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 32,
    parameter int unsigned FRAC = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         acc_en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sat_val,
    output logic         clip
);

    localparam int unsigned AW = 2 * W + clog2(N);
    localparam logic signed [AW-1:0] SatMax = AW'(sat_max(W));
    localparam logic signed [AW-1:0] SatMin = AW'(sat_min(W));

    logic signed [2*W-1:0] a_ext, b_ext, prod;
    logic signed [AW-1:0]  acc_q, acc_d, shifted;
    logic                  clip_hi, clip_lo;

    assign a_ext = {{W{a[W-1]}}, a};
    assign b_ext = {{W{b[W-1]}}, b};
    assign prod  = a_ext * b_ext;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + {{(AW - 2 * W){prod[2*W-1]}}, prod};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc_q <= '0;
        else          acc_q <= acc_d;
    end

    assign shifted = acc_q >>> FRAC;
    assign clip_hi = shifted > SatMax;
    assign clip_lo = shifted < SatMin;
    assign clip    = clip_hi | clip_lo;
    assign sat_val = clip_hi ? SatMax[W-1:0] : (clip_lo ? SatMin[W-1:0] : shifted[W-1:0]);

endmodule

// File: rtl/matmul_nxn_seq.sv
// Time-multiplexed NxN fixed-point matrix multiply, R = A*B or A*B^T,
// one result row per pass over N MAC lanes.
module matmul_nxn_seq
    import matmul_nxn_seq_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 32,
    parameter int unsigned FRAC = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             trans_b,
    input  logic             accept_in,
    input  logic [N*N*W-1:0] A,
    input  logic [N*N*W-1:0] B,
    output logic             accept_out,
    output logic             ready_out,
    output logic [N*N*W-1:0] result,
    output logic             sat_flag
);

    localparam int unsigned CW = clog2(N);
    localparam int unsigned MW = N * N * W;
    localparam logic [CW-1:0] Last = CW'(N - 1);

    state_e        state_q;
    logic [CW-1:0] r_q, k_q;
    logic [MW-1:0] a_q, b_q, result_q;
    logic          trans_q, sat_q;
    logic [W-1:0]  a_el;
    logic [W-1:0]  b_sel    [N];
    logic [W-1:0]  lane_val [N];
    logic [N-1:0]  lane_clip;
    logic          clr, acc_en;

    assign accept_out = (state_q == StIdle);
    assign ready_out  = (state_q == StReady);
    assign result     = result_q;
    assign sat_flag   = sat_q;

    // Accumulators clear on capture and after each row is written back.
    assign clr    = ((state_q == StIdle) && enable) || (state_q == StStore);
    assign acc_en = (state_q == StCompute);
    assign a_el   = a_q[elem_lsb(int'(r_q), int'(k_q), N, W) +: W];

    for (genvar j = 0; j < N; j++) begin : g_lane
        assign b_sel[j] = trans_q ? b_q[elem_lsb(j, int'(k_q), N, W) +: W]
                                  : b_q[elem_lsb(int'(k_q), j, N, W) +: W];

        matmul_mac_lane #(
            .N    (N),
            .W    (W),
            .FRAC (FRAC)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (clr),
            .acc_en  (acc_en),
            .a       (a_el),
            .b       (b_sel[j]),
            .sat_val (lane_val[j]),
            .clip    (lane_clip[j])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            r_q      <= '0;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            trans_q  <= 1'b0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        a_q     <= A;
                        b_q     <= B;
                        trans_q <= trans_b;
                        r_q     <= '0;
                        k_q     <= '0;
                        sat_q   <= 1'b0;
                        state_q <= StCompute;
                    end
                end
                StCompute: begin
                    if (k_q == Last) state_q <= StStore;
                    else             k_q     <= k_q + 1'b1;
                end
                StStore: begin
                    for (int j = 0; j < N; j++) begin
                        result_q[elem_lsb(int'(r_q), j, N, W) +: W] <= lane_val[j];
                    end
                    sat_q <= sat_q | (|lane_clip);
                    k_q   <= '0;
                    if (r_q == Last) begin
                        state_q <= StReady;
                    end else begin
                        r_q     <= r_q + 1'b1;
                        state_q <= StCompute;
                    end
                end
                StReady: begin
                    if (accept_in) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/matmul_nxn_seq.md
Name: matmul_nxn_seq

Overview:
- Parametrised, time-multiplexed fixed-point matrix multiplier for the ZF detector datapath.
- Computes R = A*B, or R = A*B^T when trans_b=1, for signed NxN matrices of W-bit QI.FRAC elements.
- Uses N multiply-accumulate lanes, one result row per pass, with saturating writeback and a saturation flag.
- Handshake is the same as the fixed 4x4 multipliers (enable / accept_out / ready_out / accept_in), so it can replace them in the detector chain.

Parameters:
- N, 4: matrix dimension (2..8).
- W, 32: element width, signed two's complement.
- FRAC, 16: fractional bits per element (0 < FRAC < W).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  start request; sampled only in IDLE.
- trans_b  in  1  0: R=A*B; 1: R=A*B^T. Sampled with enable.
- accept_in  in  1  downstream has consumed result; sampled only in READY.
- A  in  N*N*W  matrix A. Element (r,c) sits at bits [W*(N*N-1-(r*N+c)) +: W], so element (0,0) is at the MSBs.
- B  in  N*N*W  matrix B, packed the same way as A.
- accept_out  out  1  high in IDLE (block can take new operands).
- ready_out  out  1  high in READY (result valid).
- result  out  N*N*W  matrix R, packed the same way as A.
- sat_flag  out  1  at least one element of the current result saturated.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; row/k counters, accumulators, operand registers, result and sat_flag all cleared to 0.
  - accept_out=1, ready_out=0.
  - Reset asserted mid-operation aborts the operation; no partial result is retained.
- States: IDLE, COMPUTE, STORE, READY. accept_out and ready_out are decoded combinationally from state.
- IDLE:
  - On enable=1, latch A, B and trans_b into internal registers; r=0, k=0; clear accumulators and sat_flag; go to COMPUTE.
  - Operand inputs are don't-care after the capture edge.
- COMPUTE:
  - Each cycle, lane j (0..N-1): acc[j] += a[r][k] * b_sel, where b_sel = b[k][j] when trans_b=0 and b[j][k] when trans_b=1.
  - k increments each cycle. When k==N-1, go to STORE.
- STORE:
  - For each j: s = acc[j] >>> FRAC (arithmetic shift, floor rounding).
  - Saturate s to [-2^(W-1), 2^(W-1)-1] and write it to result element (r,j).
  - If any lane clipped, set sat_flag (sticky for the operation).
  - Clear accumulators, k=0.
  - If r==N-1, go to READY; otherwise r++ and go to COMPUTE.
- READY:
  - result and sat_flag are held stable.
  - accept_in=1 → IDLE on the next edge. result is retained in IDLE until the next capture.
- Widths:
  - Products are full 2W bits, signed.
  - Accumulator is 2W + clog2(N) bits, so accumulation never wraps. Only the final narrowing saturates.
- Latency: with enable sampled at edge 0, ready_out rises after edge N*(N+1). N=4 gives 20 cycles.
- Result rows update progressively during an operation; result is valid only while ready_out=1.
- Simultaneous events and ignored inputs:
  - enable outside IDLE is ignored.
  - accept_in outside READY is ignored.
  - enable and accept_in both high in READY: go to IDLE only. A new capture needs enable in IDLE on a later cycle.
  - enable held high continuously in IDLE starts back-to-back operations.

Decomposition:
- Shared package/include holds:
  - State encodings (IDLE=0, COMPUTE=1, STORE=2, READY=3).
  - The element-offset function elem_lsb(r,c,N,W) used for packing and unpacking.
  - SAT_MAX and SAT_MIN expressions derived from W.
  - The clog2 helper.
- Sub-module matmul_mac_lane, instantiated N times. Each lane contains:
  - The signed multiplier and the accumulator register.
  - Clear and accumulate enables.
  - The shift/saturate logic and the per-lane clip output.
- The top level holds the FSM, counters, operand registers, operand mux (trans_b) and result register.

Test Plan:
- Identity: N=4, W=32, FRAC=16, A=I (diagonal 0x00010000), B = elements 0x00010000*(r*4+c), trans_b=0 → result==B, sat_flag=0, ready_out after exactly 20 cycles.
- Transpose: same A=I and B with trans_b=1 → result element (r,c) == B element (c,r).
- Signed values: A all 0xFFFF8000 (-0.5), B all 0x00020000 (2.0) → every result element 0xFFFC0000 (-4.0), sat_flag=0.
- Saturation: A all 0x7FFF0000, B all 0x00020000 → every element 0x7FFFFFFF, sat_flag=1. Negate A → every element 0x80000000, sat_flag=1.
- Handshake:
  - Hold accept_in=0 for 50 cycles in READY → result and ready_out stable.
  - Pulse enable during COMPUTE → no effect.
  - enable and accept_in together in READY → IDLE, no new start.
- Reset mid-operation: drop reset_n at cycle 7 of COMPUTE → immediately accept_out=1, ready_out=0, result=0, sat_flag=0. A following clean run gives the correct result.
